// File: rtl/code_queue_ml.sv
// Context/decision queue between the bit-plane coder and the MQ coder.
// Buffers up to LANES (CX,D) pairs per cycle; emits MQ pairs or RAW-packed bytes.
module code_queue_ml #(
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    parameter int CX_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        wr_en,
    input  logic [LANES-1:0]        d_in,
    input  logic [LANES*CX_W-1:0]   cx_in,
    output logic                    in_ready,
    input  logic                    raw_mode,
    input  logic                    flush,
    output logic                    pair_valid,
    input  logic                    pair_ready,
    output logic [CX_W-1:0]         pair_cx,
    output logic                    pair_d,
    output logic                    byte_valid,
    output logic [7:0]              byte_out,
    output logic                    flush_done,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, PAD, DONE} state_t;

    state_t            state, state_next;
    logic [CX_W:0]     mem [DEPTH];
    logic [CX_W:0]     head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W-1:0]  lane_off [LANES];
    logic [CNT_W-1:0]  wr_cnt, count_next;
    logic              mode_raw;
    logic [6:0]        pk_bits;
    logic [2:0]        pk_cnt;
    logic              pop, pad_go;

    // Left-align the n pending bits and zero-fill the tail of the byte.
    function automatic logic [7:0] pad_byte(input logic [6:0] bits, input logic [2:0] n);
        pad_byte = {bits, 1'b0} << (3'd7 - n);
    endfunction

    // Enabled lanes are compacted: each lane's slot is the number of enabled lanes below it.
    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_off[i] = wr_cnt[PTR_W-1:0];
            wr_cnt      = wr_cnt + CNT_W'(wr_en[i]);
        end
    end

    assign head       = mem[rd_ptr];
    assign pop        = (count != '0) && (mode_raw || pair_ready);
    assign count_next = count + (in_ready ? wr_cnt : '0) - CNT_W'(pop);
    assign pad_go     = (state == DRAIN) && (count == '0) && mode_raw && (pk_cnt != 3'd0);
    assign pair_valid = (count != '0) && !mode_raw;
    assign pair_cx    = pair_valid ? head[CX_W:1] : '0;
    assign pair_d     = pair_valid ? head[0] : 1'b0;

    always_comb begin
        state_next = state;
        flush_done = 1'b0;
        case (state)
            IDLE:    if (flush) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = pad_go ? PAD : DONE;
            PAD:     state_next = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            in_ready   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            mode_raw   <= 1'b0;
            pk_bits    <= '0;
            pk_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_out   <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            in_ready <= (state_next == IDLE) && ((CNT_W'(DEPTH) - count_next) >= CNT_W'(LANES));
            if (in_ready)
                wr_ptr <= wr_ptr + wr_cnt[PTR_W-1:0];
            else if (wr_en != '0)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            byte_valid <= 1'b0;
            if (pop && mode_raw) begin
                if (pk_cnt == 3'd7) begin
                    byte_out   <= {pk_bits, head[0]};
                    byte_valid <= 1'b1;
                    pk_bits    <= '0;
                    pk_cnt     <= '0;
                end else begin
                    pk_bits <= {pk_bits[5:0], head[0]};
                    pk_cnt  <= pk_cnt + 3'd1;
                end
            end else if (pad_go) begin
                byte_out   <= pad_byte(pk_bits, pk_cnt);
                byte_valid <= 1'b1;
                pk_bits    <= '0;
                pk_cnt     <= '0;
            end
            // Mode only switches when nothing is buffered anywhere.
            if ((count == '0) && (pk_cnt == 3'd0) && (state == IDLE))
                mode_raw <= raw_mode;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (in_ready && wr_en[i])
                mem[wr_ptr + lane_off[i]] <= {cx_in[i*CX_W +: CX_W], d_in[i]};
    end

endmodule

// File: tb/tb_code_queue_ml.sv
// Bench for code_queue_ml: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_code_queue_ml;

    localparam int LANES = 2;
    localparam int DEPTH = 16;
    localparam int CX_W  = 5;
    localparam int P_IDLE = 0, P_DRAIN = 1, P_PAD = 2, P_DONE = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [LANES-1:0]       wr_en = '0;
    logic [LANES-1:0]       d_in = '0;
    logic [LANES*CX_W-1:0]  cx_in = '0;
    logic                   raw_mode = 1'b0;
    logic                   flush = 1'b0;
    logic                   pair_ready = 1'b0;
    logic                   in_ready, pair_valid, pair_d, byte_valid, flush_done, overflow;
    logic [CX_W-1:0]        pair_cx;
    logic [7:0]             byte_out;
    logic [$clog2(DEPTH):0] count;

    code_queue_ml #(.LANES(LANES), .DEPTH(DEPTH), .CX_W(CX_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .cx_in(cx_in),
        .in_ready(in_ready), .raw_mode(raw_mode), .flush(flush),
        .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_cx(pair_cx), .pair_d(pair_d),
        .byte_valid(byte_valid), .byte_out(byte_out), .flush_done(flush_done),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues for the buffer and the partial byte.
    logic [CX_W:0] mq[$];
    bit            mbits[$];
    int            mphase = P_IDLE;
    bit            m_mode = 0, m_in_ready = 0, m_ovf = 0, m_bv = 0;
    logic [7:0]    m_byte = '0;

    task automatic model_step();
        int n0, b0, ph0;
        logic [CX_W:0] e;
        if (rst) begin
            mq.delete(); mbits.delete();
            mphase = P_IDLE; m_mode = 0; m_in_ready = 0; m_ovf = 0; m_bv = 0; m_byte = '0;
            return;
        end
        n0 = mq.size(); b0 = mbits.size(); ph0 = mphase;
        m_bv = 0;
        if (n0 != 0 && (m_mode || pair_ready)) begin
            e = mq.pop_front();
            if (m_mode) begin
                mbits.push_back(e[0]);
                if (mbits.size() == 8) begin
                    m_byte = '0;
                    for (int i = 0; i < 8; i++) m_byte[7-i] = mbits[i];
                    m_bv = 1;
                    mbits.delete();
                end
            end
        end
        case (ph0)
            P_IDLE:  if (flush) mphase = P_DRAIN;
            P_DRAIN: if (n0 == 0) begin
                if (m_mode && b0 > 0) begin
                    m_byte = '0;
                    for (int i = 0; i < b0; i++) m_byte[7-i] = mbits[i];
                    m_bv = 1;
                    mbits.delete();
                    mphase = P_PAD;
                end else mphase = P_DONE;
            end
            P_PAD:   mphase = P_DONE;
            default: mphase = P_IDLE;
        endcase
        if (m_in_ready) begin
            for (int i = 0; i < LANES; i++)
                if (wr_en[i]) mq.push_back({cx_in[i*CX_W +: CX_W], d_in[i]});
        end else if (wr_en != '0) m_ovf = 1;
        if (n0 == 0 && b0 == 0 && ph0 == P_IDLE) m_mode = raw_mode;
        m_in_ready = (mphase == P_IDLE) && (DEPTH - mq.size() >= LANES);
    endtask

    always @(posedge clk or posedge rst) model_step();

    always @(negedge clk) begin
        check("in_ready", in_ready, m_in_ready);
        check("pair_valid", pair_valid, (mq.size() != 0) && !m_mode);
        if (mq.size() != 0 && !m_mode) begin
            check("pair_cx", pair_cx, mq[0][CX_W:1]);
            check("pair_d", pair_d, mq[0][0]);
        end
        check("byte_valid", byte_valid, m_bv);
        if (m_bv) check("byte_out", byte_out, m_byte);
        check("flush_done", flush_done, mphase == P_DONE);
        check("count", count, mq.size());
        check("overflow", overflow, m_ovf);
    end

    logic [7:0] got[$];

    task automatic tick();
        @(posedge clk);
        #1;
        if (byte_valid) got.push_back(byte_out);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] pat;
        bit rdy_seen;
        int done_at;
        bit seen;

        repeat (3) tick();
        check("lit_rst_in_ready", in_ready, 0);
        check("lit_rst_count", count, 0);
        check("lit_rst_pair_valid", pair_valid, 0);
        rst = 1'b0;
        tick();
        check("lit_in_ready_rise", in_ready, 1);

        // MQ: two lanes in one cycle, popped on consecutive cycles
        pair_ready = 1'b1;
        cx_in = {5'd4, 5'd4}; d_in = 2'b10; wr_en = 2'b11;
        tick();
        wr_en = '0;
        check("lit_a_valid", pair_valid, 1);
        check("lit_a_d0", pair_d, 0);
        check("lit_a_count", count, 2);
        tick();
        check("lit_a_d1", pair_d, 1);
        tick();
        check("lit_a_empty", count, 0);

        // Single upper lane compacts to the head
        pair_ready = 1'b0;
        wr_en = 2'b10; cx_in = {5'd9, 5'd3}; d_in = 2'b10;
        tick();
        wr_en = '0;
        check("lit_b_count", count, 1);
        check("lit_b_cx", pair_cx, 9);
        check("lit_b_d", pair_d, 1);
        pair_ready = 1'b1;
        tick();

        // Fill to full, overflow, drain across the pointer wrap
        pair_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cx_in = {5'(2*j+1), 5'(2*j)}; d_in = 2'(j); wr_en = 2'b11;
            tick();
        end
        wr_en = '0;
        check("lit_c_full", count, 16);
        check("lit_c_model_full", mq.size(), 16);
        check("lit_c_not_ready", in_ready, 0);
        wr_en = 2'b11;
        tick();
        wr_en = '0;
        check("lit_c_overflow", overflow, 1);
        check("lit_c_count_kept", count, 16);
        pair_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("lit_c_drain_cx", pair_cx, i);
            tick();
        end
        check("lit_c_drained", count, 0);

        // RAW packing: two full bytes
        pair_ready = 1'b0;
        raw_mode = 1'b1;
        tick();
        got.delete();
        pat = 16'b0011_1100_0000_1111;
        for (int j = 0; j < 8; j++) begin
            d_in = {pat[14-2*j], pat[15-2*j]}; wr_en = 2'b11;
            tick();
        end
        wr_en = '0;
        repeat (12) tick();
        check("lit_d_nbytes", got.size(), 2);
        if (got.size() == 2) begin
            check("lit_d_byte0", got[0], 8'h3C);
            check("lit_d_byte1", got[1], 8'h0F);
        end

        // RAW flush with 3 pending bits
        got.delete();
        wr_en = 2'b11; d_in = 2'b01;
        tick();
        wr_en = 2'b01; d_in = 2'b01;
        tick();
        wr_en = '0; flush = 1'b1;
        tick();
        flush = 1'b0;
        rdy_seen = 0; done_at = -1;
        for (int c = 0; c < 30 && done_at < 0; c++) begin
            if (in_ready) rdy_seen = 1;
            if (flush_done) done_at = c;
            else tick();
        end
        check("lit_e_flush_done", done_at >= 0, 1);
        check("lit_e_in_ready_low", rdy_seen, 0);
        check("lit_e_nbytes", got.size(), 1);
        if (got.size() == 1) check("lit_e_byte", got[0], 8'hA0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            wr_en = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            cx_in = 10'($urandom);
            d_in = 2'($urandom);
            pair_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) raw_mode = ~raw_mode;
            tick();
        end
        wr_en = '0; flush = 1'b0;

        // Bring to a clean idle state, then reset mid-operation in RAW
        pair_ready = 1'b1; flush = 1'b1; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (flush_done) seen = 1;
        end
        flush = 1'b0;
        check("lit_f_flush_reached", seen, 1);
        raw_mode = 1'b1;
        repeat (3) tick();
        check("lit_f_idle_empty", count, 0);
        got.delete();
        d_in = 2'b01; cx_in = {5'd7, 5'd5};
        for (int j = 0; j < 4; j++) begin
            wr_en = 2'b11;
            tick();
        end
        wr_en = '0;
        check("lit_f_count5", count, 5);
        check("lit_f_ovf_sticky", overflow, 1);
        rst = 1'b1;
        #1;
        check("lit_f_rst_count", count, 0);
        check("lit_f_rst_in_ready", in_ready, 0);
        check("lit_f_rst_overflow", overflow, 0);
        check("lit_f_rst_byte_valid", byte_valid, 0);
        check("lit_f_rst_byte_out", byte_out, 0);
        check("lit_f_rst_pair_valid", pair_valid, 0);
        check("lit_f_rst_flush_done", flush_done, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("lit_f_no_byte", got.size(), 0);
        check("lit_f_post_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
